mode_switch_pipe: RTL and testbench

MODE_SWITCH_PIPE -- requirements
Module: mode_switch_pipe

---
 rtl/mode_switch_pipe.sv | 123 ++++++++++++
 tb/tb_mode_switch_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_switch_pipe.sv
// Mode-switched NTT/INTT datapath stage: one modular multiplier per lane is shared between the
// forward (memory -> butterfly) and return (butterfly -> memory) paths, with a drain-then-switch mode handshake.
module mode_switch_pipe #(
    parameter int WIDTH    = 12,
    parameter int LANES    = 4,
    parameter int Q        = 3329,
    parameter int MULT_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES*WIDTH-1:0] in_tw,
    input  logic                   bf_valid,
    input  logic [LANES*WIDTH-1:0] bf_data,
    input  logic [LANES*WIDTH-1:0] bf_tw,
    output logic                   fwd_valid,
    output logic [LANES*WIDTH-1:0] fwd_data,
    output logic                   ret_valid,
    output logic [LANES*WIDTH-1:0] ret_data,
    input  logic                   mode_req,
    input  logic                   mode_in,
    output logic                   mode,
    output logic                   mode_ack
);

    localparam int DW = LANES * WIDTH;
    localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);

    function automatic logic [WIDTH-1:0] mod_q(input logic [2*WIDTH-1:0] p);
        logic [2*WIDTH-1:0] r;
        r = p % QW;
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [DW-1:0] lane_modmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]      res;
        logic [2*WIDTH-1:0] prod;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = {{WIDTH{1'b0}}, a[i*WIDTH +: WIDTH]} * {{WIDTH{1'b0}}, b[i*WIDTH +: WIDTH]};
            res[i*WIDTH +: WIDTH] = mod_q(prod);
        end
        return res;
    endfunction

    logic [MULT_LAT-1:0]         fwd_vld;
    logic [MULT_LAT-1:0]         ret_vld;
    logic [MULT_LAT-1:0][DW-1:0] mul_p;
    logic [MULT_LAT-1:0][DW-1:0] byp_p;
    logic                        mode_r;
    logic                        pending;
    logic                        pending_mode;
    logic                        ack_r;

    logic          accept;
    logic          drained;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_in_v;
    logic [DW-1:0] byp_in;
    logic          byp_in_v;

    assign accept   = in_valid && !pending;
    assign drained  = !(|fwd_vld) && !(|ret_vld) && !bf_valid;

    // Mode steers which path owns the multiplier; the other path rides the bypass delay line.
    assign mul_a    = mode_r ? bf_data  : in_data;
    assign mul_b    = mode_r ? bf_tw    : in_tw;
    assign mul_in_v = mode_r ? bf_valid : accept;
    assign byp_in   = mode_r ? in_data  : bf_data;
    assign byp_in_v = mode_r ? accept   : bf_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_vld <= '0;
            ret_vld <= '0;
            mul_p   <= '0;
            byp_p   <= '0;
        end else begin
            fwd_vld[0] <= accept;
            ret_vld[0] <= bf_valid;
            if (mul_in_v) mul_p[0] <= lane_modmul(mul_a, mul_b);
            if (byp_in_v) byp_p[0] <= byp_in;
            for (int k = 1; k < MULT_LAT; k++) begin
                fwd_vld[k] <= fwd_vld[k-1];
                ret_vld[k] <= ret_vld[k-1];
                if (mode_r ? ret_vld[k-1] : fwd_vld[k-1]) mul_p[k] <= mul_p[k-1];
                if (mode_r ? fwd_vld[k-1] : ret_vld[k-1]) byp_p[k] <= byp_p[k-1];
            end
        end
    end

    // A new request takes priority over applying the old one, so a late overwrite always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r       <= 1'b0;
            pending      <= 1'b0;
            pending_mode <= 1'b0;
            ack_r        <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            if (mode_req) begin
                pending      <= 1'b1;
                pending_mode <= mode_in;
            end else if (pending && drained) begin
                mode_r  <= pending_mode;
                pending <= 1'b0;
                ack_r   <= 1'b1;
            end
        end
    end

    assign in_ready  = !pending;
    assign fwd_valid = fwd_vld[MULT_LAT-1];
    assign ret_valid = ret_vld[MULT_LAT-1];
    assign fwd_data  = mode_r ? byp_p[MULT_LAT-1] : mul_p[MULT_LAT-1];
    assign ret_data  = mode_r ? mul_p[MULT_LAT-1] : byp_p[MULT_LAT-1];
    assign mode      = mode_r;
    assign mode_ack  = ack_r;

endmodule

// File: tb/tb_mode_switch_pipe.sv
// Directed bench for mode_switch_pipe (WIDTH=12, LANES=4, Q=3329, MULT_LAT=3) with hand-computed expectations.
module tb_mode_switch_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [47:0] in_tw;
    logic        bf_valid;
    logic [47:0] bf_data;
    logic [47:0] bf_tw;
    logic        fwd_valid;
    logic [47:0] fwd_data;
    logic        ret_valid;
    logic [47:0] ret_data;
    logic        mode_req;
    logic        mode_in;
    logic        mode;
    logic        mode_ack;

    int total = 0;
    int bad   = 0;

    mode_switch_pipe #(.WIDTH(12), .LANES(4), .Q(3329), .MULT_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tw(in_tw),
        .bf_valid(bf_valid), .bf_data(bf_data), .bf_tw(bf_tw),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .mode_req(mode_req), .mode_in(mode_in), .mode(mode), .mode_ack(mode_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {12'(l3), 12'(l2), 12'(l1), 12'(l0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; bf_valid = 0; mode_req = 0; mode_in = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_data = '0; in_tw = '0; bf_data = '0; bf_tw = '0;
        rst_n = 0;
        #1;
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL reset_fwd_valid got=%b want=0", fwd_valid); end
        total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL reset_ret_valid got=%b want=0", ret_valid); end
        total++; if (fwd_data !== 48'h0) begin bad++; $display("FAIL reset_fwd_data got=%h want=0", fwd_data); end
        total++; if (ret_data !== 48'h0) begin bad++; $display("FAIL reset_ret_data got=%h want=0", ret_data); end
        total++; if (mode !== 1'b0 || mode_ack !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b/%b want=0/0", mode, mode_ack); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_ntt_mul();
        in_valid = 1;
        in_data  = pack4(100, 5, 3328, 1000);
        in_tw    = pack4(200, 7, 2, 1000);
        bf_valid = 1;
        bf_data  = pack4(11, 22, 33, 44);
        bf_tw    = pack4(3000, 3000, 3000, 3000);
        tick();
        idle_inputs();
        in_data = '0; bf_data = '0;
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL ntt_early1 got=%b want=0", fwd_valid); end
        tick();
        total++; if (fwd_valid !== 1'b0 || ret_valid !== 1'b0) begin bad++; $display("FAIL ntt_early2 got=%b/%b want=0/0", fwd_valid, ret_valid); end
        tick();
        total++; if (fwd_valid !== 1'b1) begin bad++; $display("FAIL ntt_fwd_valid got=%b want=1", fwd_valid); end
        total++; if (fwd_data !== pack4(26, 35, 3327, 1300)) begin bad++; $display("FAIL ntt_fwd_data got=%h want=%h", fwd_data, pack4(26, 35, 3327, 1300)); end
        total++; if (ret_valid !== 1'b1) begin bad++; $display("FAIL ntt_ret_valid got=%b want=1", ret_valid); end
        total++; if (ret_data !== pack4(11, 22, 33, 44)) begin bad++; $display("FAIL ntt_ret_pass got=%h want=%h", ret_data, pack4(11, 22, 33, 44)); end
        tick();
        total++; if (fwd_valid !== 1'b0 || ret_valid !== 1'b0) begin bad++; $display("FAIL ntt_single_pulse got=%b/%b want=0/0", fwd_valid, ret_valid); end
    endtask

    task automatic test_boundary();
        logic [47:0] want;
        in_valid = 1;
        in_data  = pack4(0, 3328, 3328, 0);
        in_tw    = pack4(3328, 0, 3328, 0);
        tick();
        idle_inputs();
        tick(); tick();
        want = pack4(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (fwd_data[i*12 +: 12] !== want[i*12 +: 12] || fwd_valid !== 1'b1) begin
                bad++; $display("FAIL boundary_lane%0d got=%0d v=%b want=%0d", i, fwd_data[i*12 +: 12], fwd_valid, want[i*12 +: 12]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 22; j++) begin
            in_valid = (j < 16);
            in_data  = pack4(j + 1, j + 1, j + 1, j + 1);
            in_tw    = pack4(1, 2, 3, 4);
            tick();
            if (j >= 2 && j - 2 < 16) begin
                total++;
                if (fwd_valid !== 1'b1 || fwd_data !== pack4(j - 1, 2 * (j - 1), 3 * (j - 1), 4 * (j - 1))) begin
                    bad++; $display("FAIL b2b_word%0d got=%h v=%b want=%h", j - 2, fwd_data, fwd_valid, pack4(j - 1, 2 * (j - 1), 3 * (j - 1), 4 * (j - 1)));
                end
            end else if (j >= 18) begin
                total++;
                if (fwd_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail%0d got=%b want=0", j, fwd_valid); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_same_mode();
        mode_req = 1; mode_in = 0;
        tick();
        mode_req = 0;
        total++; if (in_ready !== 1'b0 || mode_ack !== 1'b0) begin bad++; $display("FAIL same_pending got=%b/%b want=0/0", in_ready, mode_ack); end
        tick();
        total++; if (mode_ack !== 1'b1 || mode !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL same_ack got=%b/%b/%b want=1/0/1", mode_ack, mode, in_ready); end
        tick();
        total++; if (mode_ack !== 1'b0) begin bad++; $display("FAIL same_ack_pulse got=%b want=0", mode_ack); end
    endtask

    task automatic test_overwrite();
        int seen;
        seen = 0;
        mode_req = 1; mode_in = 1; in_valid = 1;
        in_data = pack4(1, 1, 1, 1); in_tw = pack4(1, 1, 1, 1);
        tick();
        in_valid = 0; mode_in = 0;
        tick();
        mode_req = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (mode_ack === 1'b1) seen = 1;
        end
        total++; if (seen != 1 || mode !== 1'b0) begin bad++; $display("FAIL overwrite got ack=%0d mode=%b want ack=1 mode=0", seen, mode); end
        tick();
    endtask

    task automatic test_ret_drain();
        int ack_at;
        ack_at = 0;
        mode_req = 1; mode_in = 1; bf_valid = 1;
        bf_data = pack4(7, 8, 9, 10); bf_tw = pack4(2, 2, 2, 2);
        for (int i = 1; i <= 20 && ack_at == 0; i++) begin
            tick();
            mode_req = 0;
            bf_valid = (i < 3);
            if (i == 5) begin
                total++; if (mode !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL retdrain_hold got mode=%b rdy=%b want 0/0", mode, in_ready); end
            end
            if (mode_ack === 1'b1) ack_at = i;
        end
        idle_inputs();
        total++; if (ack_at != 7) begin bad++; $display("FAIL retdrain_ack_cycle got=%0d want=7", ack_at); end
        total++; if (mode !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL retdrain_mode got=%b/%b want=1/1", mode, in_ready); end
        tick();
    endtask

    task automatic test_intt();
        in_valid = 1; in_data = pack4(1234, 1234, 1234, 1234); in_tw = pack4(5, 5, 5, 5);
        bf_valid = 1; bf_data = pack4(3328, 3328, 3328, 3328); bf_tw = pack4(3328, 3328, 3328, 3328);
        tick();
        in_data = pack4(3328, 0, 17, 9); in_tw = pack4(3328, 3328, 3328, 3328);
        bf_data = pack4(3328, 0, 100, 1); bf_tw = pack4(3328, 3328, 200, 5);
        tick();
        idle_inputs();
        tick();
        total++; if (ret_valid !== 1'b1 || ret_data !== pack4(1, 1, 1, 1)) begin bad++; $display("FAIL intt_ret1 got=%h v=%b want=%h", ret_data, ret_valid, pack4(1, 1, 1, 1)); end
        total++; if (fwd_valid !== 1'b1 || fwd_data !== pack4(1234, 1234, 1234, 1234)) begin bad++; $display("FAIL intt_fwd1 got=%h v=%b want=%h", fwd_data, fwd_valid, pack4(1234, 1234, 1234, 1234)); end
        tick();
        total++; if (ret_valid !== 1'b1 || ret_data !== pack4(1, 0, 26, 5)) begin bad++; $display("FAIL intt_ret2 got=%h v=%b want=%h", ret_data, ret_valid, pack4(1, 0, 26, 5)); end
        total++; if (fwd_valid !== 1'b1 || fwd_data !== pack4(3328, 0, 17, 9)) begin bad++; $display("FAIL intt_fwd2 got=%h v=%b want=%h", fwd_data, fwd_valid, pack4(3328, 0, 17, 9)); end
        tick();
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        in_valid = 1; in_data = pack4(3, 3, 3, 3); in_tw = pack4(1, 1, 1, 1);
        tick(); tick();
        in_valid = 0;
        tick();
        total++; if (fwd_valid !== 1'b1) begin bad++; $display("FAIL rstmid_inflight got=%b want=1", fwd_valid); end
        rst_n = 0;
        #1;
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b want=0", fwd_valid); end
        tick();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fwd_valid !== 1'b0 || ret_valid !== 1'b0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rstmid_stray got=%0d want=0", stray); end
        total++; if (mode !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_state got=%b/%b want=0/1", mode, in_ready); end
    endtask

    task automatic test_mode_switch();
        int ack_at;
        int fwd_cnt;
        int rdy_bad;
        ack_at = 0; fwd_cnt = 0; rdy_bad = 0;
        mode_req = 1; mode_in = 1; in_valid = 1;
        in_data = pack4(100, 100, 100, 100); in_tw = pack4(200, 200, 200, 200);
        for (int i = 1; i <= 20 && ack_at == 0; i++) begin
            tick();
            mode_req = 0;
            in_valid = (i < 4);
            if (i < 4 && in_ready !== 1'b0) rdy_bad++;
            if (fwd_valid === 1'b1) begin
                fwd_cnt++;
                total++; if (fwd_data !== pack4(26, 26, 26, 26)) begin bad++; $display("FAIL switch_old_mode got=%h want=%h", fwd_data, pack4(26, 26, 26, 26)); end
            end
            if (mode_ack === 1'b1) ack_at = i;
        end
        idle_inputs();
        total++; if (rdy_bad != 0) begin bad++; $display("FAIL switch_block got=%0d want=0", rdy_bad); end
        total++; if (fwd_cnt != 1) begin bad++; $display("FAIL switch_accepted got=%0d want=1", fwd_cnt); end
        total++; if (ack_at != 5) begin bad++; $display("FAIL switch_ack_cycle got=%0d want=5", ack_at); end
        total++; if (mode !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL switch_mode got=%b/%b want=1/1", mode, in_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ntt_mul();
        test_boundary();
        test_back_to_back();
        test_same_mode();
        test_overwrite();
        test_ret_drain();
        test_intt();
        test_reset_mid();
        test_mode_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
